hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage core. Detects load-use hazards in ID, flushes
//  IF/ID on a taken BEQ resolved in EX, and freezes the pipe while the data memory is busy (MEM stage).

---
 rtl/hazard_stall_ctrl_pkg.sv | 25 ++
 rtl/hazard_stall_ctrl_sat_counter.sv | 23 ++
 rtl/hazard_stall_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller and the main control decoder:
// opcode constants, sequencer state encoding and register-source decode.
package hazard_stall_ctrl_pkg;

  localparam logic [2:0] OP_R    = 3'd0;
  localparam logic [2:0] OP_BEQ  = 3'd2;
  localparam logic [2:0] OP_ADDI = 3'd3;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_SW   = 3'd6;

  typedef enum logic {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } state_e;

  function automatic logic uses_rs(input logic [2:0] op);
    return (op == OP_R) || (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  // Unknown opcodes read no registers, so they can never raise a hazard.
  function automatic logic uses_rt(input logic [2:0] op);
    return (op == OP_R) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module hazard_stall_ctrl_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stall, taken-branch flush and data-memory freeze,
// with saturating debug counters and a sticky memory-timeout flag.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_hold,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic              mem_timeout
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] WaitLast = TW'(MEM_TIMEOUT - 1);

  state_e state_q, state_d;
  logic   freeze, load_use, wait_cycle;
  logic   mem_timeout_q;
  logic [TW-1:0] wait_cnt;

  assign freeze   = mem_req & ~mem_ready;
  assign load_use = ex_memread && (ex_rt != '0) &&
                    ((uses_rs(id_opcode) && (id_rs == ex_rt)) ||
                     (uses_rt(id_opcode) && (id_rt == ex_rt)));

  // The cycle that enters MEM_WAIT already counts as a wait cycle.
  assign wait_cycle = (state_q == StRun) ? freeze : ~mem_ready;

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    unique case (state_q)
      StRun:     if (freeze) state_d = StMemWait;
      StMemWait: if (mem_ready) state_d = StRun;
      default:   state_d = StRun;
    endcase
    if (reset) begin
      state_d     = StRun;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (freeze) begin
      // Branch and load-use inputs persist through the freeze and are re-evaluated on release.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StRun;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wait_cycle && (wait_cnt == WaitLast)) mem_timeout_q <= 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;

  hazard_stall_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (~pc_write),
    .count (stall_count)
  );

  hazard_stall_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (ifid_flush),
    .count (flush_count)
  );

  hazard_stall_ctrl_sat_counter #(.W(TW)) u_wait_cnt (
    .clock (clock),
    .reset (reset | ~wait_cycle),
    .inc   (1'b1),
    .count (wait_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a rule-level model checked every cycle plus literal
// expectations for the key scenarios.
module tb_hazard_stall_ctrl;

  localparam int unsigned REG_AW      = 3;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned MEM_TIMEOUT = 3;
  localparam int          CNT_MAX     = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [2:0]        id_opcode;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rt;
  logic              ex_memread, ex_branch_taken, mem_req, mem_ready;
  logic              pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_timeout;
  logic [CNT_W-1:0]  stall_count, flush_count;

  int n_vec = 0;
  int n_err = 0;

  // Model state: expected counters, sticky flag and length of the current memory wait.
  int m_stall = 0;
  int m_flush = 0;
  int m_to    = 0;
  int m_run   = 0;

  hazard_stall_ctrl #(
    .REG_AW      (REG_AW),
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .id_opcode       (id_opcode),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .pipe_hold       (pipe_hold),
    .stall_count     (stall_count),
    .flush_count     (flush_count),
    .mem_timeout     (mem_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit reads_rs(input logic [2:0] op);
    int srcs[5] = '{0, 2, 3, 5, 6};
    foreach (srcs[i]) if (int'(op) == srcs[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit reads_rt(input logic [2:0] op);
    int srcs[3] = '{0, 2, 6};
    foreach (srcs[i]) if (int'(op) == srcs[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Expected outputs packed as {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}.
  function automatic logic [4:0] expect_out();
    bit hz;
    hz = ex_memread && (ex_rt != 0) &&
         ((reads_rs(id_opcode) && id_rs == ex_rt) || (reads_rt(id_opcode) && id_rt == ex_rt));
    if (reset) return 5'b00110;
    if (mem_req && !mem_ready) return 5'b00001;
    if (ex_branch_taken) return 5'b11110;
    if (hz) return 5'b00010;
    return 5'b11000;
  endfunction

  always @(negedge clock) begin
    logic [4:0] e;
    e = expect_out();
    chk("pc_write",    int'(pc_write),    int'(e[4]));
    chk("ifid_write",  int'(ifid_write),  int'(e[3]));
    chk("ifid_flush",  int'(ifid_flush),  int'(e[2]));
    chk("idex_bubble", int'(idex_bubble), int'(e[1]));
    chk("pipe_hold",   int'(pipe_hold),   int'(e[0]));
    chk("stall_count", int'(stall_count), m_stall);
    chk("flush_count", int'(flush_count), m_flush);
    chk("mem_timeout", int'(mem_timeout), m_to);
    if (reset) begin
      m_stall = 0;
      m_flush = 0;
      m_to    = 0;
      m_run   = 0;
    end else begin
      if (!e[4] && m_stall < CNT_MAX) m_stall++;
      if (e[2] && m_flush < CNT_MAX) m_flush++;
      if (mem_req && !mem_ready) begin
        m_run++;
        if (m_run >= MEM_TIMEOUT) m_to = 1;
      end else begin
        m_run = 0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_opcode = 3'd7; id_rs = '0; id_rt = '0;
    ex_memread = 1'b0; ex_rt = '0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step();
    #1;
    chk("reset_flush",  int'(ifid_flush), 1);
    chk("reset_pc",     int'(pc_write), 0);
    chk("reset_stalls", int'(stall_count), 0);
    reset = 1'b0;

    // Load-use: LW r3 in EX, R-type reading r3 in ID.
    ex_memread = 1'b1; ex_rt = 3'd3; id_opcode = 3'd0; id_rs = 3'd3; id_rt = 3'd1;
    #1;
    chk("lu_pc",     int'(pc_write), 0);
    chk("lu_ifid",   int'(ifid_write), 0);
    chk("lu_bubble", int'(idex_bubble), 1);
    step();
    ex_memread = 1'b0;
    #1;
    chk("lu_clear_pc", int'(pc_write), 1);
    chk("lu_count",    int'(stall_count), 1);
    step();

    // r0 never hazards; ADDI does not read rt.
    ex_memread = 1'b1; ex_rt = 3'd0; id_opcode = 3'd0; id_rs = 3'd0; id_rt = 3'd0;
    #1;
    chk("r0_pc", int'(pc_write), 1);
    step();
    ex_rt = 3'd3; id_opcode = 3'd3; id_rs = 3'd1; id_rt = 3'd3;
    #1;
    chk("addi_rt_pc", int'(pc_write), 1);
    step();

    // Taken branch overrides load-use.
    ex_rt = 3'd3; id_opcode = 3'd0; id_rs = 3'd3; ex_branch_taken = 1'b1;
    #1;
    chk("br_flush",  int'(ifid_flush), 1);
    chk("br_bubble", int'(idex_bubble), 1);
    chk("br_pc",     int'(pc_write), 1);
    step();
    idle();
    #1;
    chk("br_flush_count", int'(flush_count), 1);
    chk("br_stall_count", int'(stall_count), 1);
    step();

    // Four-cycle memory wait with a taken branch deferred to the release cycle.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    #1;
    chk("mw_hold",  int'(pipe_hold), 1);
    chk("mw_flush", int'(ifid_flush), 0);
    step();
    step();
    chk("mw_to_before", int'(mem_timeout), 0);
    step();
    chk("mw_to_after", int'(mem_timeout), 1);
    step();
    mem_ready = 1'b1;
    #1;
    chk("mw_rel_flush", int'(ifid_flush), 1);
    chk("mw_rel_pc",    int'(pc_write), 1);
    chk("mw_rel_hold",  int'(pipe_hold), 0);
    step();
    idle();
    #1;
    chk("mw_stalls", int'(stall_count), 4);
    chk("mw_flushes", int'(flush_count), 1);
    step();

    // Five-cycle wait past the timeout, then reset clears the sticky flag.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (5) step();
    mem_ready = 1'b1;
    step();
    idle();
    #1;
    chk("to_sticky", int'(mem_timeout), 1);
    chk("to_stalls", int'(stall_count), 5);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("to_reset_flag",  int'(mem_timeout), 0);
    chk("to_reset_stall", int'(stall_count), 0);

    // Reset in the middle of a wait abandons it.
    step();
    mem_req = 1'b1; mem_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    #1;
    chk("abandon_pc",   int'(pc_write), 1);
    chk("abandon_hold", int'(pipe_hold), 0);
    step();
    step();
    chk("abandon_to", int'(mem_timeout), 0);

    // Twenty load-use stalls saturate the 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      ex_memread = 1'b1; ex_rt = 3'd2; id_opcode = 3'd6; id_rs = 3'd1; id_rt = 3'd2;
      step();
      idle();
      step();
    end
    chk("sat_stalls", int'(stall_count), 15);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
